// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word/address types, special instruction encodings
// and the fetch-stage state enum. Decode and the CPU top reuse these.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [WORD_W-1:0] addr_t;

    localparam word_t NOP_INSTR  = 32'h0000_0000;
    localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage : mips_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports: clk, rst (async, active-high); load captures instr/pc4 as a valid
// instruction; squash loads a bubble and wins over load; neither holds.
// Outputs id_instr, id_pc4, id_valid are the registered contents.
module if_id_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  squash,
    input  word_t instr,
    input  addr_t pc4,
    output word_t id_instr,
    output addr_t id_pc4,
    output logic  id_valid
);

    // Bubble on reset or squash; otherwise load or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instr <= NOP_INSTR;
            id_pc4   <= '0;
            id_valid <= 1'b0;
        end else if (squash) begin
            id_instr <= NOP_INSTR;
            id_pc4   <= '0;
            id_valid <= 1'b0;
        end else if (load) begin
            id_instr <= instr;
            id_pc4   <= pc4;
            id_valid <= 1'b1;
        end
    end

endmodule : if_id_reg

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory address,
// handles stall/redirect and sequences pipeline drain after the halt word.
// Ports: clk, rst (async, active-high); stall, redirect, redirect_pc from
// hazard/branch logic; imem_addr/imem_data to instruction memory;
// id_instr/id_pc4/id_valid form the IF/ID register; pc is the debug PC;
// halted rises once the drain after a halt has completed.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter addr_t       RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH   = 512,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  redirect,
    input  addr_t redirect_pc,
    output addr_t imem_addr,
    input  word_t imem_data,
    output word_t id_instr,
    output addr_t id_pc4,
    output logic  id_valid,
    output addr_t pc,
    output logic  halted
);

    localparam int unsigned CNT_W      = $clog2(DRAIN_CYCLES + 1);
    localparam addr_t       IMEM_BYTES = 32'(IMEM_DEPTH * 4);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    addr_t            pc_q, pc_d;
    logic             halted_q, halted_d;
    logic             load_c, squash_c;
    word_t            fetched_c;
    addr_t            pc4_c;

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign pc4_c     = pc_q + 32'd4;

    // Addresses past the end of instruction memory read as the halt word.
    assign fetched_c = (pc_q >= IMEM_BYTES) ? HALT_INSTR : imem_data;

    // State, PC, drain counter and halt flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            cnt_q    <= '0;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    // Next-state and IF/ID control; redirect beats stall, HALTED ignores both.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        load_c   = 1'b0;
        squash_c = 1'b0;

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d     = redirect_pc & ~32'h0000_0003;
                    squash_c = 1'b1;
                    cnt_d    = '0;
                end else if (!stall) begin
                    load_c = 1'b1;
                    if (fetched_c == HALT_INSTR) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        pc_d = pc4_c;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_d     = redirect_pc & ~32'h0000_0003;
                    squash_c = 1'b1;
                    cnt_d    = '0;
                    state_d  = FETCH;
                end else if (!stall) begin
                    squash_c = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .squash   (squash_c),
        .instr    (fetched_c),
        .pc4      (pc4_c),
        .id_instr (id_instr),
        .id_pc4   (id_pc4),
        .id_valid (id_valid)
    );

endmodule : mips_fetch_stage
